// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the shared-data-memory arbiter.
//   arb_state_e : arbiter FSM encoding (idle / grant / release turnaround).
//   owner_w()   : width of an owner index for a given requester count.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT   = 2'b01,
    S_RELEASE = 2'b10
  } arb_state_e;

  localparam int N_REQ_DEFAULT = 5;

  // $clog2(n_req), kept at least 1 bit so a single requester still has an index.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W_DEFAULT = owner_w(N_REQ_DEFAULT);

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: requester/memory bus of the shared-data-memory arbiter.
//   i_Grant_Request  [n_req]        level request per requester (0 = control unit)
//   i_Memory_Address [n_req][addr]  per-requester address slices
//   i_Write_Enable   [n_req]        per-requester write strobe
//   i_Write_Data     [n_req][32]    per-requester write data
//   o_Grant          [n_req]        registered one-hot grant (or zero)
//   o_Mem_*                         owner's address / write strobe / data to memory
//   i_Mem_Read_Data, o_Read_Data    memory read data, broadcast to all requesters
// Modports: slave = arbiter side, master = requesters + memory side.
interface memory_arbiter_if #(
  parameter int n_req           = 5,
  parameter int memory_size_log = 10
);
  logic [n_req-1:0]                      i_Grant_Request;
  logic [n_req-1:0][memory_size_log-1:0] i_Memory_Address;
  logic [n_req-1:0]                      i_Write_Enable;
  logic [n_req-1:0][31:0]                i_Write_Data;
  logic [n_req-1:0]                      o_Grant;
  logic [memory_size_log-1:0]            o_Mem_Address;
  logic                                  o_Mem_Write_Enable;
  logic [31:0]                           o_Mem_Write_Data;
  logic [31:0]                           i_Mem_Read_Data;
  logic [31:0]                           o_Read_Data;

  modport slave (
    input  i_Grant_Request, i_Memory_Address, i_Write_Enable, i_Write_Data,
           i_Mem_Read_Data,
    output o_Grant, o_Mem_Address, o_Mem_Write_Enable, o_Mem_Write_Data,
           o_Read_Data
  );

  modport master (
    output i_Grant_Request, i_Memory_Address, i_Write_Enable, i_Write_Data,
           i_Mem_Read_Data,
    input  o_Grant, o_Mem_Address, o_Mem_Write_Enable, o_Mem_Write_Data,
           o_Read_Data
  );
endinterface

// File: rtl/memory_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   last  : index of the previous owner; search starts at last+1 and wraps
//   win   : winning index (0 when nothing requests)
//   valid : at least one request present
module rr_pick
  import memory_arbiter_pkg::*;
#(
  parameter int n_req = 5,
  parameter int ow    = owner_w(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [ow-1:0]    last,
  output logic [ow-1:0]    win,
  output logic             valid
);

  // Each requester's distance from last+1 (mod n_req); smallest distance wins.
  always_comb begin : p_pick
    int d;
    int best;
    d     = 0;
    best  = n_req;
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < n_req; k++) begin
      d = (k + n_req - 1 - int'(last)) % n_req;
      if (req[k] && d < best) begin
        best  = d;
        win   = ow'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin grant responder for the shared data memory.
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   bus (slave)        : requests/addresses/data in, grant and memory port out
//   o_Timeout          : one-cycle pulse when a held grant is revoked
//                        (only when ARB_TIMEOUT_EN is defined)
// Optional feature macro: ARB_TIMEOUT_EN (grant watchdog of timeout_cycles).
// Every grant is followed by a one-cycle S_RELEASE and a pass through S_IDLE,
// so ownership changes always leave two cycles with no owner.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int n_req           = 5,
  parameter int memory_size_log = 10,
  parameter int timeout_cycles  = 255
) (
  input  logic            i_Clock,
  input  logic            i_Reset_n,
  memory_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
  ,
  output logic            o_Timeout
`endif
);

  localparam int OW = owner_w(n_req);

  arb_state_e       state, nxt_state;
  logic [OW-1:0]    r_Owner, nxt_owner;
  logic [OW-1:0]    r_Last_Owner, nxt_last;
  logic [OW-1:0]    pick_win;
  logic             pick_vld;
  logic [n_req-1:0] r_Grant, nxt_grant;
  logic             revoke;
  logic             owned;

  rr_pick #(.n_req(n_req), .ow(OW)) u_rr_pick (
    .req   (bus.i_Grant_Request),
    .last  (r_Last_Owner),
    .win   (pick_win),
    .valid (pick_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(timeout_cycles + 1);
  logic [CW-1:0] r_cnt;

  // Counter holds 0 outside S_GRANT, so it is clear on every grant entry.
  assign revoke = (state == S_GRANT) && (r_cnt == CW'(timeout_cycles));

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_cnt     <= '0;
      o_Timeout <= 1'b0;
    end else begin
      o_Timeout <= revoke;
      if (state != S_GRANT) r_cnt <= '0;
      else if (!revoke)     r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign revoke         = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= S_IDLE;
      r_Owner      <= '0;
      r_Last_Owner <= OW'(n_req - 1);
      r_Grant      <= '0;
    end else begin
      state        <= nxt_state;
      r_Owner      <= nxt_owner;
      r_Last_Owner <= nxt_last;
      r_Grant      <= nxt_grant;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = r_Owner;
    nxt_last  = r_Last_Owner;
    nxt_grant = r_Grant;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          nxt_owner           = pick_win;
          nxt_grant           = '0;
          nxt_grant[pick_win] = 1'b1;
          nxt_state           = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.i_Grant_Request[r_Owner] || revoke) begin
          nxt_grant = '0;
          nxt_last  = r_Owner;
          nxt_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        nxt_grant = '0;
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_grant = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Memory-side mux keyed on the registered owner; zero whenever nobody owns.
  assign owned                  = (state == S_GRANT);
  assign bus.o_Grant            = r_Grant;
  assign bus.o_Mem_Address      = owned ? bus.i_Memory_Address[r_Owner] : '0;
  assign bus.o_Mem_Write_Enable = owned & bus.i_Write_Enable[r_Owner];
  assign bus.o_Mem_Write_Data   = owned ? bus.i_Write_Data[r_Owner] : '0;
  assign bus.o_Read_Data        = bus.i_Mem_Read_Data;

endmodule
